hilo_md_ctrl: RTL and testbench

HILO_MD_CTRL -- requirements
Module: hilo_md_ctrl

---
 rtl/hilo_md_ctrl_pkg.sv | 25 ++
 rtl/hilo_md_ctrl_div.sv | 68 ++++++
 rtl/hilo_md_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hilo_md_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_md_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: md_op codes,
// FSM state codes, default iteration parameters and an operand magnitude helper.
package hilo_md_ctrl_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int ITER_DEF  = 32;
    localparam int CNT_W_DEF = 5;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_md_ctrl_div.sv
// md_div_core: restoring divider on operand magnitudes, one quotient bit per cycle.
// Results are presented combinationally during the final step so the owner can commit on that edge.
module md_div_core
    import hilo_md_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        abort,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        valid
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rem_q, quo_q, dsr_q;
    logic             qneg_q, rneg_q;
    logic [32:0]      shifted;
    logic             ge;
    logic [31:0]      rem_nx, quo_nx;

    // When the trial subtract succeeds the true difference is below 2^32,
    // so a 32-bit modular subtract of the low bits is exact.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        ge      = (shifted >= {1'b0, dsr_q});
        rem_nx  = ge ? (shifted[31:0] - dsr_q) : shifted[31:0];
        quo_nx  = {quo_q[30:0], ge};
    end

    assign quotient  = qneg_q ? (~quo_nx + 32'd1) : quo_nx;
    assign remainder = rneg_q ? (~rem_nx + 32'd1) : rem_nx;
    assign valid     = busy_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= 32'd0;
            quo_q  <= mag32(dividend, signed_op);
            dsr_q  <= mag32(divisor, signed_op);
            qneg_q <= signed_op & (dividend[31] ^ divisor[31]);
            rneg_q <= signed_op & dividend[31];
        end else if (busy_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            if (valid) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide controller: FSM, architectural HI/LO and EX handshake.
// MD_FAST_MUL_EN swaps the iterative shift-add multiplier for a single-cycle one.
//   state  | meaning
//   IDLE   | ready, MTHI/MTLO write directly
//   MUL    | multiply in progress
//   DIV    | divide in progress (md_div_core stepping)
//   DONE   | one cycle, md_done asserted
module hilo_md_ctrl
    import hilo_md_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        ex_valid_ns,
    input  logic        wb_allin,
    input  logic [2:0]  md_op,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        ex_allin,
    output logic        md_busy,
    output logic        md_done
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             accept, is_signed, is_mul, is_div, div_start;
    logic             div_valid;
    logic [31:0]      div_quo, div_rem;
    logic             mneg_q;
    logic [63:0]      mul_mag, mul_res;

    assign accept    = ex_valid_ns & wb_allin & (state_q == S_IDLE) & (md_op != OP_NONE);
    assign is_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    assign is_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_div    = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign div_start = accept & ~flush & is_div & (src1 != 32'd0);

`ifdef MD_FAST_MUL_EN
    logic [31:0] ma_q, mb_q;

    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            ma_q   <= mag32(src0, is_signed);
            mb_q   <= mag32(src1, is_signed);
            mneg_q <= is_signed & (src0[31] ^ src1[31]);
        end
    end

    assign mul_mag = {32'd0, ma_q} * {32'd0, mb_q};
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
    logic [63:0] mcand_q, acc_q;
    logic [31:0] mplier_q;

    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand_q  <= {32'd0, mag32(src0, is_signed)};
            mplier_q <= mag32(src1, is_signed);
            acc_q    <= 64'd0;
            mneg_q   <= is_signed & (src0[31] ^ src1[31]);
        end else if (state_q == S_MUL) begin
            acc_q    <= mul_mag;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    // Partial product including this cycle's bit, so the last step commits directly.
    assign mul_mag = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
`endif

    assign mul_res = mneg_q ? (~mul_mag + 64'd1) : mul_mag;

    md_div_core #(.CNT_W(CNT_W), .ITER(ITER)) u_div (
        .clk       (clk),
        .reset     (reset),
        .abort     (flush),
        .start     (div_start),
        .signed_op (is_signed),
        .dividend  (src0),
        .divisor   (src1),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                        end
                        OP_DIV, OP_DIVU: state_d = (src1 == 32'd0) ? S_DONE : S_DIV;
                        OP_MTHI:         hi_d = src0;
                        OP_MTLO:         lo_d = src0;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
`ifdef MD_FAST_MUL_EN
                state_d      = S_DONE;
                {hi_d, lo_d} = mul_res;
`else
                if (cnt_q == LAST) begin
                    state_d      = S_DONE;
                    cnt_d        = '0;
                    {hi_d, lo_d} = mul_res;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DIV: begin
                if (div_valid) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign ex_allin = (state_q == S_IDLE);
    assign md_busy  = (state_q == S_MUL) || (state_q == S_DIV);
    assign md_done  = (state_q == S_DONE) & ~flush & ~reset;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Self-checking bench for hilo_md_ctrl: directed table, corner sequences
// (flush, reset, divide by zero, back-to-back MTHI/MTLO) and random ops vs. an arithmetic model.
module tb_hilo_md_ctrl;

    localparam int ITER  = 32;
    localparam int CNT_W = 5;
`ifdef MD_FAST_MUL_EN
    localparam int L_MUL = 1;
`else
    localparam int L_MUL = ITER;
`endif

    localparam logic [2:0] T_NONE = 3'd0, T_MULT = 3'd1, T_MULTU = 3'd2, T_DIV = 3'd3,
                           T_DIVU = 3'd4, T_MTHI = 3'd5, T_MTLO = 3'd6;

    logic        clk = 1'b0;
    logic        reset, flush, ex_valid_ns, wb_allin;
    logic [2:0]  md_op;
    logic [31:0] src0, src1;
    logic [31:0] hi, lo;
    logic        ex_allin, md_busy, md_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    hilo_md_ctrl #(.CNT_W(CNT_W), .ITER(ITER)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .ex_valid_ns (ex_valid_ns),
        .wb_allin    (wb_allin),
        .md_op       (md_op),
        .src0        (src0),
        .src1        (src1),
        .hi          (hi),
        .lo          (lo),
        .ex_allin    (ex_allin),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero, remainder follows dividend.
    task automatic model(input logic [2:0] op, input logic [31:0] a, b,
                         input logic [31:0] hi_in, lo_in,
                         output logic [31:0] hi_o, lo_o, output int lat);
        longint sa, sb, sp;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi_o = hi_in;
        lo_o = lo_in;
        lat  = -1;
        case (op)
            T_MULT:  begin sp = sa * sb; p = sp; {hi_o, lo_o} = p; lat = L_MUL; end
            T_MULTU: begin p = ua * ub; {hi_o, lo_o} = p; lat = L_MUL; end
            T_DIV: begin
                if (b == 32'd0) lat = 0;
                else begin
                    sp = sa / sb; p = sp; lo_o = p[31:0];
                    sp = sa % sb; p = sp; hi_o = p[31:0];
                    lat = ITER;
                end
            end
            T_DIVU: begin
                if (b == 32'd0) lat = 0;
                else begin
                    p = ua / ub; lo_o = p[31:0];
                    p = ua % ub; hi_o = p[31:0];
                    lat = ITER;
                end
            end
            T_MTHI: hi_o = a;
            T_MTLO: lo_o = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, b,
                          input logic [31:0] exp_hi, exp_lo, input int exp_lat, input string tag);
        int  k;
        int  lat_seen;
        k = 0;
        while (!ex_allin && k < ITER + 10) begin
            @(posedge clk); #1; k++;
        end
        check({tag, ".ready"}, {63'd0, ex_allin}, 64'd1);
        ex_valid_ns = 1'b1; wb_allin = 1'b1;
        md_op = op; src0 = a; src1 = b;
        @(posedge clk); #1;
        if (exp_lat < 0) begin
            ex_valid_ns = 1'b0; md_op = T_NONE;
            check({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
            check({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
            check({tag, ".mt_done"}, {63'd0, md_done}, 64'd0);
            check({tag, ".mt_allin"}, {63'd0, ex_allin}, 64'd1);
            return;
        end
        // A MULT held on the bus while busy must be ignored; operands are scrambled.
        md_op = T_MULT; src0 = $urandom; src1 = $urandom;
        check({tag, ".busy"}, {63'd0, md_busy}, (exp_lat > 0) ? 64'd1 : 64'd0);
        k = 0;
        lat_seen = -1;
        while (k <= ITER + 5) begin
            if (md_done) begin lat_seen = k; break; end
            if (ex_allin) break;
            @(posedge clk); #1; k++;
            src0 = $urandom; src1 = $urandom;
        end
        ex_valid_ns = 1'b0; md_op = T_NONE;
        check({tag, ".latency"}, 64'(lat_seen), 64'(exp_lat));
        check({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, ".allin_done"}, {63'd0, ex_allin}, 64'd0);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, {63'd0, md_done}, 64'd0);
        check({tag, ".allin_after"}, {63'd0, ex_allin}, 64'd1);
    endtask

    initial begin
        logic [31:0] eh, el;
        int lat, dones;

        tbl[0]  = '{T_MTHI,  32'h0000_0011, 32'h0,          32'h0000_0011, 32'h1234_5678};
        tbl[1]  = '{T_MTLO,  32'h0000_0022, 32'h0,          32'h0000_0011, 32'h0000_0022};
        tbl[2]  = '{T_DIV,   32'h0000_0005, 32'h0,          32'h0000_0011, 32'h0000_0022};
        tbl[3]  = '{T_MULT,  32'hFFFF_FFFE, 32'h3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[4]  = '{T_DIVU,  32'd100,       32'd7,          32'd2,         32'd14};
        tbl[5]  = '{T_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[6]  = '{T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        tbl[7]  = '{T_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000};
        tbl[8]  = '{T_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0};
        tbl[9]  = '{T_DIVU,  32'hFFFF_FFFF, 32'd1,          32'h0,         32'hFFFF_FFFF};
        tbl[10] = '{T_DIVU,  32'd3,         32'hFFFF_FFFF,  32'd3,         32'h0};
        tbl[11] = '{T_MULT,  32'd7,         32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFF9};

        reset = 1'b1; flush = 1'b0; ex_valid_ns = 1'b0; wb_allin = 1'b1;
        md_op = T_NONE; src0 = 32'd0; src1 = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst.hi", {32'd0, hi}, 64'd0);
        check("rst.lo", {32'd0, lo}, 64'd0);
        check("rst.allin", {63'd0, ex_allin}, 64'd1);
        check("rst.busy", {63'd0, md_busy}, 64'd0);
        check("rst.done", {63'd0, md_done}, 64'd0);

        // Back-to-back MTHI then MTLO.
        ex_valid_ns = 1'b1; md_op = T_MTHI; src0 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("b2b.hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("b2b.lo0", {32'd0, lo}, 64'd0);
        check("b2b.done0", {63'd0, md_done}, 64'd0);
        md_op = T_MTLO; src0 = 32'h1234_5678;
        @(posedge clk); #1;
        ex_valid_ns = 1'b0; md_op = T_NONE;
        check("b2b.lo", {32'd0, lo}, {32'd0, 32'h1234_5678});
        check("b2b.hi1", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        check("b2b.idle", {63'd0, ex_allin}, 64'd1);
        check("b2b.done1", {63'd0, md_done}, 64'd0);
        m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;

        for (int i = 0; i < 12; i++) begin
            model(tbl[i].op, tbl[i].a, tbl[i].b, m_hi, m_lo, eh, el, lat);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, lat, $sformatf("tbl%0d", i));
            m_hi = tbl[i].hi; m_lo = tbl[i].lo;
        end

        // Flush at iteration 10 of a DIV with HI=0x11, LO=0x22.
        run_op(T_MTHI, 32'h11, 32'h0, 32'h11, m_lo, -1, "pre.hi");
        run_op(T_MTLO, 32'h22, 32'h0, 32'h11, 32'h22, -1, "pre.lo");
        m_hi = 32'h11; m_lo = 32'h22;
        ex_valid_ns = 1'b1; md_op = T_DIV; src0 = 32'h1234; src1 = 32'd5;
        @(posedge clk); #1;
        ex_valid_ns = 1'b0; md_op = T_NONE;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.allin", {63'd0, ex_allin}, 64'd1);
        check("flush.busy", {63'd0, md_busy}, 64'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (md_done) dones++;
            @(posedge clk); #1;
        end
        check("flush.no_done", 64'(dones), 64'd0);
        check("flush.hi", {32'd0, hi}, 64'h11);
        check("flush.lo", {32'd0, lo}, 64'h22);

        // flush beats a same-cycle accept; wb_allin low blocks accept.
        ex_valid_ns = 1'b1; md_op = T_MTHI; src0 = 32'hABCD; flush = 1'b1;
        @(posedge clk); #1;
        check("fprio.hi", {32'd0, hi}, 64'h11);
        md_op = T_MULT;
        @(posedge clk); #1;
        check("fprio.allin", {63'd0, ex_allin}, 64'd1);
        flush = 1'b0; wb_allin = 1'b0;
        @(posedge clk); #1;
        check("wb_block.allin", {63'd0, ex_allin}, 64'd1);
        ex_valid_ns = 1'b0; md_op = T_NONE; wb_allin = 1'b1;

        // Reset mid-multiply clears HI/LO and returns to IDLE.
        ex_valid_ns = 1'b1; md_op = T_MULT; src0 = 32'd5; src1 = 32'd6;
        @(posedge clk); #1;
        ex_valid_ns = 1'b0; md_op = T_NONE;
        repeat (L_MUL > 1 ? 5 : 0) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid.hi", {32'd0, hi}, 64'd0);
        check("rstmid.lo", {32'd0, lo}, 64'd0);
        check("rstmid.allin", {63'd0, ex_allin}, 64'd1);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (md_done) dones++;
            @(posedge clk); #1;
        end
        check("rstmid.no_done", 64'(dones), 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int sel;
            op  = 3'($urandom_range(1, 6));
            a   = $urandom;
            sel = $urandom_range(0, 3);
            b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            model(op, a, b, m_hi, m_lo, eh, el, lat);
            run_op(op, a, b, eh, el, lat, $sformatf("rnd%0d", i));
            m_hi = eh; m_lo = el;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
